// File: rtl/gate_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_unit : pipelined WIDTH-bit bitwise logic unit with accumulator,     |
// |             valid/ready handshake and registered result + reductions.    |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic [CNTW-1:0]  txn_cnt
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;

  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] sel,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_ANDN: r = x & ~y;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ov_q, ov_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             w_in_fire;

  // Ready depends only on occupancy and the consumer, never on in_valid.
  assign in_ready  = !ov_q || out_ready;
  assign w_in_fire = in_valid && in_ready;

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    ov_d  = ov_q;
    cnt_d = cnt_q;
    if (w_in_fire) begin
      cnt_d = cnt_q + CNTW'(1);
      ov_d  = 1'b1;
      if (acc_mode) begin
        acc_d = acc_first ? a : f_op(op, acc_q, a);
        c_d   = acc_d;
      end else begin
        c_d = f_op(op, a, b);
      end
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      c_q   <= '0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      c_q   <= c_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign c         = c_q;
  assign red_and   = &c_q;
  assign red_or    = |c_q;
  assign red_xor   = ^c_q;
  assign txn_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_unit.sv
`default_nettype none
// Bench for gate_unit: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_gate_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       acc_mode = 1'b0, acc_first = 1'b0, out_ready = 1'b1;

  logic        in_ready, out_valid, red_and, red_or, red_xor;
  logic [7:0]  c;
  logic [15:0] txn_cnt;
  logic        in_ready2, out_valid2, red_and2, red_or2, red_xor2;
  logic [7:0]  c2;
  logic [1:0]  txn_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_unit #(.WIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_first(acc_first),
    .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .red_and(red_and), .red_or(red_or), .red_xor(red_xor), .txn_cnt(txn_cnt)
  );

  gate_unit #(.WIDTH(8), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_first(acc_first),
    .out_valid(out_valid2), .out_ready(out_ready), .c(c2),
    .red_and(red_and2), .red_or(red_or2), .red_xor(red_xor2), .txn_cnt(txn_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the operation table written directly from its definition.
  function automatic logic [7:0] ref_op(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return x;
    endcase
  endfunction

  logic [7:0] m_acc = '0, m_c = '0;
  bit         m_ov = 1'b0;
  int         m_cnt = 0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_acc = '0; m_c = '0; m_ov = 1'b0; m_cnt = 0; m_live = 1'b1;
    end else if (m_live) begin
      if (in_valid && (!m_ov || out_ready)) begin
        m_cnt = m_cnt + 1;
        if (acc_mode) begin
          m_acc = acc_first ? a : ref_op(op, m_acc, a);
          m_c   = m_acc;
        end else begin
          m_c = ref_op(op, a, b);
        end
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      chk("m_in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
      chk("m_c", 32'(c), 32'(m_c));
      chk("m_red_and", 32'(red_and), 32'(m_c == 8'hFF));
      chk("m_red_or", 32'(red_or), 32'(m_c != 8'h00));
      chk("m_red_xor", 32'(red_xor), 32'($countones(m_c) % 2));
      chk("m_txn_cnt", 32'(txn_cnt), 32'(m_cnt % 65536));
      chk("m_txn_cnt2", 32'(txn_cnt2), 32'(m_cnt % 4));
    end
  end

  task automatic beat(input bit v, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [2:0] o, input bit am, input bit af, input bit ordy);
    in_valid = v; a = aa; b = bb; op = o; acc_mode = am; acc_first = af; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] sweep [8];
    sweep = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};

    @(posedge clk); #1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_c", 32'(c), 0);
    chk("rst_txn", 32'(txn_cnt), 0);
    chk("rst_reds", {29'd0, red_and, red_or, red_xor}, 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      beat(1, 8'hF0, 8'h3C, 3'(i), 0, 0, 1);
      chk("sweep_c", 32'(c), 32'(sweep[i]));
      chk("sweep_ov", 32'(out_valid), 1);
    end
    chk("sweep_txn", 32'(txn_cnt), 8);
    beat(0, 0, 0, 0, 0, 0, 1);

    beat(1, 8'h0F, 8'h00, 3'd0, 1, 1, 1);
    chk("acc_load", 32'(c), 32'h0F);
    beat(1, 8'h33, 8'h00, 3'd2, 1, 0, 1);
    chk("acc_xor1", 32'(c), 32'h3C);
    beat(1, 8'hFF, 8'h00, 3'd2, 1, 0, 1);
    chk("acc_xor2", 32'(c), 32'hC3);
    chk("acc_reds", {29'd0, red_and, red_or, red_xor}, 32'b010);
    beat(0, 0, 0, 0, 0, 0, 1);

    do_reset();
    beat(1, 8'h12, 8'hFF, 3'd0, 0, 0, 0);
    chk("bp_first_c", 32'(c), 32'h12);
    chk("bp_first_txn", 32'(txn_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      beat(1, 8'h34, 8'hFF, 3'd0, 0, 0, 0);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_c_stable", 32'(c), 32'h12);
      chk("bp_txn_stable", 32'(txn_cnt), 1);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("bp_drain_c", 32'(c), 32'h34);
    chk("bp_drain_txn", 32'(txn_cnt), 2);
    chk("bp_drain_ov", 32'(out_valid), 1);

    beat(1, 8'hAA, 8'h00, 3'd0, 1, 1, 1);
    chk("il_load", 32'(c), 32'hAA);
    beat(1, 8'hFF, 8'h01, 3'd0, 0, 0, 1);
    chk("il_pair", 32'(c), 32'h01);
    beat(1, 8'h55, 8'h00, 3'd1, 1, 0, 1);
    chk("il_or", 32'(c), 32'hFF);
    chk("il_red_and", 32'(red_and), 1);

    rst = 1'b1;
    beat(1, 8'h77, 8'h11, 3'd1, 0, 0, 1);
    rst = 1'b0;
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_c", 32'(c), 0);
    chk("mid_rst_txn", 32'(txn_cnt), 0);
    beat(1, 8'h0F, 8'h00, 3'd1, 1, 0, 1);
    chk("mid_rst_acc_or", 32'(c), 32'h0F);
    do_reset();
    beat(1, 8'hFF, 8'h00, 3'd0, 1, 0, 1);
    chk("mid_rst_acc_and", 32'(c), 32'h00);

    do_reset();
    begin
      int wrap_exp [5];
      wrap_exp = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
        beat(1, 8'(i), 8'h00, 3'd7, 0, 0, 1);
        chk("wrap_cnt2", 32'(txn_cnt2), 32'(wrap_exp[i]));
      end
    end

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 127) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 3'($urandom);
      acc_mode  = 1'($urandom);
      acc_first = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
